// File: rtl/trans_scheduler.sv
// Round-robin issue front-end for the transaction validator.
// Define TRANS_SCHED_STATS_EN to add per-port issue counters.
module trans_scheduler #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS*128-1:0]     in_data_i,
  input  logic [NUM_PORTS-1:0]         in_valid_i,
  output logic [NUM_PORTS-1:0]         in_ready_o,
  output logic [127:0]                 data_o,
  output logic                         valid_o,
  output logic [$clog2(NUM_PORTS)-1:0] grant_o,
  input  logic                         dst_ready_i
`ifdef TRANS_SCHED_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]      stat_count_o
`endif
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [127:0]         data_q, data_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        sel, cand;
  logic                 found;
  logic [NUM_PORTS-1:0] push, pop;
  logic [NUM_PORTS-1:0] ready_q, ready_d;
  logic [PW-1:0]        wr_q [NUM_PORTS];
  logic [PW-1:0]        wr_d [NUM_PORTS];
  logic [PW-1:0]        rd_q [NUM_PORTS];
  logic [PW-1:0]        rd_d [NUM_PORTS];
  logic [CW-1:0]        cnt_q [NUM_PORTS];
  logic [CW-1:0]        cnt_d [NUM_PORTS];
  logic [127:0]         mem_q [NUM_PORTS][FIFO_DEPTH];

  // First non-empty port after the last grant, with wrap
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = GW'((int'(last_q) + i) % NUM_PORTS);
      if (!found && cnt_q[cand] != '0) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Issue FSM: pop and register in IDLE, strobe, then blind HOLD
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    pop     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (dst_ready_i && found) begin
          pop[sel] = 1'b1;
          data_d   = mem_q[sel][rd_q[sel]];
          grant_d  = sel;
          last_d   = sel;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-port FIFO pointers, occupancy and registered ready
  always_comb begin
    push = in_valid_i & ready_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_d[p]    = wr_q[p] + PW'(push[p]);
      rd_d[p]    = rd_q[p] + PW'(pop[p]);
      cnt_d[p]   = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
      ready_d[p] = cnt_d[p] < CW'(FIFO_DEPTH);
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= GW'(NUM_PORTS - 1);
      ready_q <= '1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_q[p]  <= '0;
        rd_q[p]  <= '0;
        cnt_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_q[p]  <= wr_d[p];
        rd_q[p]  <= rd_d[p];
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  // FIFO storage, written on accepted pushes
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) begin
        mem_q[p][wr_q[p]] <= in_data_i[p*128 +: 128];
      end
    end
  end

  assign data_o     = data_q;
  assign valid_o    = (state_q == S_ISSUE);
  assign grant_o    = grant_q;
  assign in_ready_o = ready_q;

`ifdef TRANS_SCHED_STATS_EN
  logic [NUM_PORTS-1:0][31:0] stat_q, stat_d;

  // Count strobes per granted port, wrapping at 32 bits
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      stat_d[p] = stat_q[p] + 32'(valid_o && grant_q == GW'(p));
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_count_o = stat_q;
`endif

endmodule
